// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the serial program loader.
// The timeout helper is only referenced when UART_LOADER_TIMEOUT_EN is defined.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_LO,
        ST_ADDR_HI,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM
    } state_e;

    typedef logic [1:0] err_code_t;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;

    localparam err_code_t  ERR_NONE    = 2'b00;
    localparam err_code_t  ERR_CSUM    = 2'b01;
    localparam err_code_t  ERR_OVERRUN = 2'b10;
    localparam err_code_t  ERR_TIMEOUT = 2'b11;

    // Inter-byte timeout expressed in clock cycles.
    function automatic int unsigned timeout_cycles(input int unsigned clk_freq,
                                                   input int unsigned timeout_us);
        return (clk_freq / 32'd1000000) * timeout_us;
    endfunction

endpackage

// File: rtl/uart_loader_if.sv
// Byte-stream input, RAM write port and status outputs of the loader.
// master is the loader side, slave is the surrounding system (UART, RAM, CPU).
interface uart_loader_if;
    import uart_loader_pkg::*;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_ack;
    logic        cpu_hold;
    logic        done;
    logic        err;
    err_code_t   err_code;

    modport master (
        input  rx_data, rx_valid, mem_ack,
        output mem_addr, mem_wdata, mem_we, cpu_hold, done, err, err_code
    );

    modport slave (
        output rx_data, rx_valid, mem_ack,
        input  mem_addr, mem_wdata, mem_we, cpu_hold, done, err, err_code
    );

endinterface

// File: rtl/uart_loader_timer.sv
// Loadable down-counter; expired pulses for one cycle as the count runs out.
// Only instantiated when UART_LOADER_TIMEOUT_EN is defined.
module uart_loader_timer #(
    parameter int unsigned LOAD_VAL = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam int W = (LOAD_VAL < 2) ? 1 : $clog2(LOAD_VAL + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        expired = 1'b0;
        if (load) begin
            cnt_d = W'(LOAD_VAL);
        end else if (run && (cnt_q != '0)) begin
            cnt_d   = cnt_q - W'(1);
            expired = (cnt_q == W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_loader.sv
// Framed serial loader: parses A5/addr/len/data/csum records into RAM writes and
// releases the CPU on a zero-length frame. Optional timeout: UART_LOADER_TIMEOUT_EN.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 184333000,
    parameter int unsigned TIMEOUT_US = 10000
) (
    input  logic          clk,
    input  logic          rst,
    uart_loader_if.master bus
);

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  sum_next;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    err_code_t   err_code_q, err_code_d;
    logic        overrun;
    logic        timeout_hit;

`ifdef UART_LOADER_TIMEOUT_EN
    localparam int unsigned TIMEOUT_CYCLES = timeout_cycles(CLK_FREQ, TIMEOUT_US);

    uart_loader_timer #(
        .LOAD_VAL (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (bus.rx_valid),
        .run     (state_q != ST_IDLE),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    assign sum_next = sum_q + bus.rx_data;
    // A byte arriving while the previous write is still unacknowledged cannot be stored.
    assign overrun  = bus.rx_valid && mem_we_q && !bus.mem_ack;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = 1'b0;
        err_d       = err_q;
        err_code_d  = err_code_q;

        if (mem_we_q && bus.mem_ack) mem_we_d = 1'b0;

        if (overrun) begin
            state_d = ST_IDLE;
            if (!err_q) begin
                err_d      = 1'b1;
                err_code_d = ERR_OVERRUN;
            end
        end else if (bus.rx_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.rx_data == SYNC_BYTE) begin
                        state_d    = ST_ADDR_LO;
                        cpu_hold_d = 1'b1;
                        err_d      = 1'b0;
                        err_code_d = ERR_NONE;
                        sum_d      = 8'h00;
                    end
                end
                ST_ADDR_LO: begin
                    addr_d  = {addr_q[15:8], bus.rx_data};
                    sum_d   = sum_next;
                    state_d = ST_ADDR_HI;
                end
                ST_ADDR_HI: begin
                    addr_d  = {bus.rx_data, addr_q[7:0]};
                    sum_d   = sum_next;
                    state_d = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    len_d   = {len_q[15:8], bus.rx_data};
                    sum_d   = sum_next;
                    state_d = ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    len_d   = {bus.rx_data, len_q[7:0]};
                    cnt_d   = {bus.rx_data, len_q[7:0]};
                    sum_d   = sum_next;
                    state_d = ({bus.rx_data, len_q[7:0]} == 16'h0000) ? ST_CSUM : ST_DATA;
                end
                ST_DATA: begin
                    mem_addr_d  = addr_q;
                    mem_wdata_d = bus.rx_data;
                    mem_we_d    = 1'b1;
                    addr_d      = addr_q + 16'd1;
                    cnt_d       = cnt_q - 16'd1;
                    sum_d       = sum_next;
                    if (cnt_q == 16'd1) state_d = ST_CSUM;
                end
                ST_CSUM: begin
                    state_d = ST_IDLE;
                    if (sum_next == 8'h00) begin
                        if (len_q != 16'h0000) done_d     = 1'b1;
                        else                   cpu_hold_d = 1'b0;
                    end else if (!err_q) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CSUM;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (timeout_hit) begin
            // Abandon the frame; an outstanding write is left to finish on its own.
            state_d = ST_IDLE;
            if (!err_q) begin
                err_d      = 1'b1;
                err_code_d = ERR_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
            mem_we_q    <= 1'b0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    // Frame bookkeeping is always loaded before use, so it carries no reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        len_q  <= len_d;
        cnt_q  <= cnt_d;
        sum_q  <= sum_d;
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed, table-driven bench for uart_loader: per-cycle input/expected-output vectors
// plus hand-written reset and timeout sequences.
module tb_uart_loader;
    import uart_loader_pkg::*;

    logic clk = 1'b0;
    logic rst;

    uart_loader_if bus ();

    uart_loader #(
        .CLK_FREQ   (10000000),
        .TIMEOUT_US (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [7:0]  data;
        logic        ack;
        logic [29:0] exp;
        string       name;
    } vec_t;

    vec_t       vecs[$];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] fsum;

    function automatic logic [29:0] pk(input logic we, input logic [15:0] a, input logic [7:0] wd,
                                       input logic h, input logic d, input logic e,
                                       input logic [1:0] c);
        return {we, a, wd, h, d, e, c};
    endfunction

    function automatic logic [7:0] fld(input logic [7:0] b);
        fsum = fsum + b;
        return b;
    endfunction

    function automatic logic [7:0] good();
        return 8'h00 - fsum;
    endfunction

    function automatic void add(input string name, input logic rv, input logic [7:0] data,
                                input logic ack, input logic [29:0] exp);
        vec_t v;
        v.rv = rv; v.data = data; v.ack = ack; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endfunction

    // Sync plus four header fields; outputs stay idle apart from hold/err clearing.
    function automatic void hdr(input string name, input logic [7:0] alo, input logic [7:0] ahi,
                                input logic [7:0] llo, input logic [7:0] lhi,
                                input logic [15:0] a, input logic [7:0] wd);
        fsum = 8'h00;
        add({name, "_sync"}, 1'b1, SYNC_BYTE, 1'b1, pk(0, a, wd, 1, 0, 0, 2'b00));
        add({name, "_alo"},  1'b1, fld(alo),  1'b1, pk(0, a, wd, 1, 0, 0, 2'b00));
        add({name, "_ahi"},  1'b1, fld(ahi),  1'b1, pk(0, a, wd, 1, 0, 0, 2'b00));
        add({name, "_llo"},  1'b1, fld(llo),  1'b1, pk(0, a, wd, 1, 0, 0, 2'b00));
        add({name, "_lhi"},  1'b1, fld(lhi),  1'b1, pk(0, a, wd, 1, 0, 0, 2'b00));
    endfunction

    task automatic step(input logic rv, input logic [7:0] d, input logic ack);
        bus.rx_valid = rv;
        bus.rx_data  = d;
        bus.mem_ack  = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [29:0] exp);
        logic [29:0] act;
        act = {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_hold, bus.done, bus.err, bus.err_code};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got we=%b addr=%h wdata=%h hold=%b done=%b err=%b code=%b, expected we=%b addr=%h wdata=%h hold=%b done=%b err=%b code=%b",
                     name, act[29], act[28:13], act[12:5], act[4], act[3], act[2], act[1:0],
                     exp[29], exp[28:13], exp[12:5], exp[4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.mem_ack  = 1'b0;
        fsum         = 8'h00;

        // Load frame: three writes to 0x1000..0x1002, done pulses once.
        hdr("load", 8'h00, 8'h10, 8'h03, 8'h00, 16'h0000, 8'h00);
        add("load_d0",   1, fld(8'h11), 1, pk(1, 16'h1000, 8'h11, 1, 0, 0, 2'b00));
        add("load_d1",   1, fld(8'h22), 1, pk(1, 16'h1001, 8'h22, 1, 0, 0, 2'b00));
        add("load_d2",   1, fld(8'h33), 1, pk(1, 16'h1002, 8'h33, 1, 0, 0, 2'b00));
        add("load_csum", 1, good(),     1, pk(0, 16'h1002, 8'h33, 1, 1, 0, 2'b00));
        add("load_idle", 0, 8'h00,      1, pk(0, 16'h1002, 8'h33, 1, 0, 0, 2'b00));
        // Run frame: no writes, hold released, no done.
        hdr("run", 8'h00, 8'h00, 8'h00, 8'h00, 16'h1002, 8'h33);
        add("run_csum",  1, good(),     1, pk(0, 16'h1002, 8'h33, 0, 0, 0, 2'b00));
        add("run_idle",  0, 8'h00,      1, pk(0, 16'h1002, 8'h33, 0, 0, 0, 2'b00));
        // Bad checksum on one byte to 0x2000: byte still written, sticky error.
        hdr("bad", 8'h00, 8'h20, 8'h01, 8'h00, 16'h1002, 8'h33);
        add("bad_d0",    1, fld(8'h5A), 1, pk(1, 16'h2000, 8'h5A, 1, 0, 0, 2'b00));
        add("bad_csum",  1, good() + 8'h01, 1, pk(0, 16'h2000, 8'h5A, 1, 0, 1, 2'b01));
        add("bad_idle0", 0, 8'h00,      1, pk(0, 16'h2000, 8'h5A, 1, 0, 1, 2'b01));
        add("bad_idle1", 1, 8'h12,      1, pk(0, 16'h2000, 8'h5A, 1, 0, 1, 2'b01));
        // Wrap: sync clears the error, writes land at 0xFFFF then 0x0000.
        hdr("wrap", 8'hFF, 8'hFF, 8'h02, 8'h00, 16'h2000, 8'h5A);
        add("wrap_d0",   1, fld(8'hD1), 1, pk(1, 16'hFFFF, 8'hD1, 1, 0, 0, 2'b00));
        add("wrap_d1",   1, fld(8'hD2), 1, pk(1, 16'h0000, 8'hD2, 1, 0, 0, 2'b00));
        add("wrap_csum", 1, good(),     1, pk(0, 16'h0000, 8'hD2, 1, 1, 0, 2'b00));
        add("wrap_idle", 0, 8'h00,      1, pk(0, 16'h0000, 8'hD2, 1, 0, 0, 2'b00));
        // Overrun: second byte while the first write is unacknowledged.
        hdr("ovr", 8'h00, 8'h30, 8'h02, 8'h00, 16'h0000, 8'hD2);
        add("ovr_d0",    1, 8'h44, 0, pk(1, 16'h3000, 8'h44, 1, 0, 0, 2'b00));
        add("ovr_d1",    1, 8'h55, 0, pk(1, 16'h3000, 8'h44, 1, 0, 1, 2'b10));
        add("ovr_stall", 0, 8'h00, 0, pk(1, 16'h3000, 8'h44, 1, 0, 1, 2'b10));
        add("ovr_ack",   0, 8'h00, 1, pk(0, 16'h3000, 8'h44, 1, 0, 1, 2'b10));
        // A5 is taken as sync only if the overrun returned the FSM to IDLE.
        hdr("same", 8'h00, 8'h40, 8'h02, 8'h00, 16'h3000, 8'h44);
        add("same_d0",   1, fld(8'h66), 0, pk(1, 16'h4000, 8'h66, 1, 0, 0, 2'b00));
        add("same_d1",   1, fld(8'h77), 1, pk(1, 16'h4001, 8'h77, 1, 0, 0, 2'b00));
        add("same_csum", 1, good(),     1, pk(0, 16'h4001, 8'h77, 1, 1, 0, 2'b00));
        add("same_idle", 0, 8'h00,      1, pk(0, 16'h4001, 8'h77, 1, 0, 0, 2'b00));

        repeat (3) @(posedge clk);
        #1;
        check("reset_values", pk(0, 16'h0000, 8'h00, 1, 0, 0, 2'b00));
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].rv, vecs[i].data, vecs[i].ack);
            check(vecs[i].name, vecs[i].exp);
        end

        // Reset after a run frame restores cpu_hold.
        step(1, SYNC_BYTE, 1);
        repeat (5) step(1, 8'h00, 1);
        check("hand_run_release", pk(0, 16'h4001, 8'h77, 0, 0, 0, 2'b00));
        rst = 1'b1;
        step(0, 8'h00, 0);
        check("rst_after_run", pk(0, 16'h0000, 8'h00, 1, 0, 0, 2'b00));
        rst = 1'b0;

        // Reset mid-frame with a pending write and a sticky error.
        step(1, SYNC_BYTE, 0);
        step(1, 8'h00, 0);
        step(1, 8'h50, 0);
        step(1, 8'h01, 0);
        step(1, 8'h00, 0);
        step(1, 8'h88, 0);
        check("mid_pending", pk(1, 16'h5000, 8'h88, 1, 0, 0, 2'b00));
        step(1, 8'h99, 0);
        check("mid_overrun", pk(1, 16'h5000, 8'h88, 1, 0, 1, 2'b10));
        rst = 1'b1;
        step(0, 8'h00, 0);
        check("rst_mid_frame", pk(0, 16'h0000, 8'h00, 1, 0, 0, 2'b00));
        rst = 1'b0;
        step(1, 8'h00, 1);
        step(1, 8'h50, 1);
        step(1, 8'h01, 1);
        step(1, 8'h00, 1);
        step(1, 8'h88, 1);
        check("post_rst_no_sync", pk(0, 16'h0000, 8'h00, 1, 0, 0, 2'b00));

`ifdef UART_LOADER_TIMEOUT_EN
        // 10 MHz, 1 us: expiry ten cycles after the last byte.
        step(1, SYNC_BYTE, 1);
        step(1, 8'h00, 1);
        repeat (9) step(0, 8'h00, 1);
        check("tmo_before", pk(0, 16'h0000, 8'h00, 1, 0, 0, 2'b00));
        step(0, 8'h00, 1);
        check("tmo_expired", pk(0, 16'h0000, 8'h00, 1, 0, 1, 2'b11));
        step(1, 8'h00, 1);
        check("tmo_idle", pk(0, 16'h0000, 8'h00, 1, 0, 1, 2'b11));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
